// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the instruction-fetch and load/store requesters.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating priority; the default build uses fixed data-over-fetch priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wmask,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                timeout
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_e;
  typedef enum logic {GNT_IF = 1'b0, GNT_D = 1'b1} grant_e;

  state_e              state_q,      state_d;
  grant_e              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic                mem_req_q,    mem_req_d;
  logic                mem_we_q,     mem_we_d;
  logic [MASK_W-1:0]   mem_wmask_q,  mem_wmask_d;
  logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
  logic                if_valid_q,   if_valid_d;
  logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
  logic                d_valid_q,    d_valid_d;
  logic [DATA_W-1:0]   d_rdata_q,    d_rdata_d;
  logic                timeout_q,    timeout_d;

  logic                qual_if, qual_d, pick_d;
  logic [CNT_W-1:0]    cnt_inc;

  // Next-state: grant in IDLE, wait for ack or timeout while busy
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_wmask_d  = mem_wmask_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_valid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_valid_d    = 1'b0;
    d_rdata_d    = d_rdata_q;
    timeout_d    = timeout_q;

    // A requester whose valid is high this cycle has just been served.
    qual_if = if_req & ~if_valid_q;
    qual_d  = d_req & ~d_valid_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick_d  = qual_d & (~qual_if | (last_grant_q == GNT_IF));
`else
    pick_d  = qual_d;
`endif
    cnt_inc = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_wmask_d = d_we ? d_wmask : '0;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = GNT_D;
`endif
        end else if (qual_if) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_wmask_d = '0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = GNT_IF;
`endif
        end
      end
      BUSY_IF, BUSY_D: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          if (state_q == BUSY_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          cnt_d     = '0;
          timeout_d = 1'b1;
          if (state_q == BUSY_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = '0;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_IF;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wmask_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_valid_q    <= 1'b0;
      d_rdata_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_valid_q   <= if_valid_d;
      if_rdata_q   <= if_rdata_d;
      d_valid_q    <= d_valid_d;
      d_rdata_q    <= d_rdata_d;
      timeout_q    <= timeout_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, timeout/reset sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned TMO = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_wmask;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
  } ins_t;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        timeout;
  } outs_t;

  typedef struct packed {
    ins_t  i;
    outs_t o;
  } vec_t;

  // Reference model: who owns the memory, how long it has waited, who was granted last.
  typedef struct packed {
    logic [1:0] owner;   // 0 none, 1 fetch, 2 data
    logic [7:0] waited;
    logic       last_d;
    outs_t      o;
  } mstate_t;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wmask;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ins_t mk_i(logic rs, logic ir, logic [31:0] ia, logic dr, logic dwe,
                                logic [3:0] dm, logic [31:0] da, logic [31:0] dwd,
                                logic ack, logic [31:0] rd);
    ins_t v;
    v.rst_n = rs; v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dwe;
    v.d_wmask = dm; v.d_addr = da; v.d_wdata = dwd; v.mem_ack = ack; v.mem_rdata = rd;
    return v;
  endfunction

  function automatic outs_t mk_o(logic mr, logic mw, logic [3:0] mm, logic [31:0] ma,
                                 logic [31:0] mwd, logic iv, logic [31:0] ird, logic dv,
                                 logic [31:0] drd, logic to);
    outs_t o;
    o.mem_req = mr; o.mem_we = mw; o.mem_wmask = mm; o.mem_addr = ma; o.mem_wdata = mwd;
    o.if_valid = iv; o.if_rdata = ird; o.d_valid = dv; o.d_rdata = drd; o.timeout = to;
    return o;
  endfunction

  // One clock of the arbiter's rules, computed from the transaction's point of view.
  function automatic mstate_t model_step(mstate_t s, ins_t v);
    mstate_t n;
    logic    qi, qd, take_d, timed;
    logic [31:0] r;
    n = s;
    n.o.if_valid = 1'b0;
    n.o.d_valid  = 1'b0;
    if (!v.rst_n) begin
      n = '0;
      return n;
    end
    if (s.owner == 2'd0) begin
      qi = v.if_req && !s.o.if_valid;
      qd = v.d_req && !s.o.d_valid;
      take_d = qd && (!qi || !RR || !s.last_d);
      if (take_d) begin
        n.owner = 2'd2; n.last_d = 1'b1; n.o.mem_req = 1'b1; n.o.mem_we = v.d_we;
        n.o.mem_wmask = v.d_we ? v.d_wmask : 4'h0;
        n.o.mem_addr = v.d_addr; n.o.mem_wdata = v.d_wdata;
      end else if (qi) begin
        n.owner = 2'd1; n.last_d = 1'b0; n.o.mem_req = 1'b1; n.o.mem_we = 1'b0;
        n.o.mem_wmask = 4'h0; n.o.mem_addr = v.if_addr;
      end
    end else if (v.mem_ack || (int'(s.waited) + 1 >= int'(TMO))) begin
      timed = !v.mem_ack;
      r = timed ? 32'h0 : v.mem_rdata;
      n.owner = 2'd0; n.waited = 8'd0; n.o.mem_req = 1'b0;
      if (timed) n.o.timeout = 1'b1;
      if (s.owner == 2'd1) begin
        n.o.if_valid = 1'b1; n.o.if_rdata = r;
      end else begin
        n.o.d_valid = 1'b1;
        if (timed || !s.o.mem_we) n.o.d_rdata = r;
      end
    end else begin
      n.waited = s.waited + 8'd1;
    end
    return n;
  endfunction

  task automatic drive(ins_t v);
    rst_n = v.rst_n; if_req = v.if_req; if_addr = v.if_addr; d_req = v.d_req;
    d_we = v.d_we; d_wmask = v.d_wmask; d_addr = v.d_addr; d_wdata = v.d_wdata;
    mem_ack = v.mem_ack; mem_rdata = v.mem_rdata;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full output comparison; write data only matters when a store is presented.
  task automatic check(string nm, outs_t e);
    logic ok;
    ok = (mem_req === e.mem_req) && (mem_we === e.mem_we) && (mem_wmask === e.mem_wmask) &&
         (mem_addr === e.mem_addr) && (!e.mem_we || (mem_wdata === e.mem_wdata)) &&
         (if_valid === e.if_valid) && (if_rdata === e.if_rdata) &&
         (d_valid === e.d_valid) && (d_rdata === e.d_rdata) && (timeout === e.timeout);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s t=%0t: got req=%b we=%b m=%h a=%h wd=%h iv=%b ir=%h dv=%b dr=%h to=%b / want req=%b we=%b m=%h a=%h wd=%h iv=%b ir=%h dv=%b dr=%h to=%b",
               nm, $time, mem_req, mem_we, mem_wmask, mem_addr, mem_wdata, if_valid, if_rdata,
               d_valid, d_rdata, timeout, e.mem_req, e.mem_we, e.mem_wmask, e.mem_addr,
               e.mem_wdata, e.if_valid, e.if_rdata, e.d_valid, e.d_rdata, e.timeout);
    end
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %h want %h", nm, $time, got, want);
    end
  endtask

  vec_t tbl[$];

  function automatic void add(ins_t a, outs_t b);
    vec_t v;
    v.i = a;
    v.o = b;
    tbl.push_back(v);
  endfunction

  initial begin
    mstate_t m;
    ins_t    v;
    logic    if_act, d_act;
    logic [31:0] ra, rd_a, r_wd;
    logic [3:0]  r_m;
    logic        r_we;
    int          hi, nv;
    logic [31:0] vd;
    logic        vto;
    logic [31:0] w_a, l_a;

    // Stray ack, store with 3-cycle wait, 2-cycle fetch, contention, then priority policy.
    add(mk_i(1,0,0,     0,0,0,0,0,                     1,32'h1234),
        mk_o(0,0,0,0,0,                     0,0,0,0,0));
    add(mk_i(1,0,0,     1,1,4'hF,32'h100,32'hDEADBEEF, 0,0),
        mk_o(1,1,4'hF,32'h100,32'hDEADBEEF, 0,0,0,0,0));
    add(mk_i(1,0,0,     1,1,4'hF,32'h100,32'hDEADBEEF, 0,0),
        mk_o(1,1,4'hF,32'h100,32'hDEADBEEF, 0,0,0,0,0));
    add(mk_i(1,0,0,     1,1,4'hF,32'h100,32'hDEADBEEF, 0,0),
        mk_o(1,1,4'hF,32'h100,32'hDEADBEEF, 0,0,0,0,0));
    add(mk_i(1,0,0,     1,1,4'hF,32'h100,32'hDEADBEEF, 1,32'hCAFEF00D),
        mk_o(0,1,4'hF,32'h100,32'hDEADBEEF, 0,0,1,0,0));
    add(mk_i(1,0,0,     0,0,0,0,0,                     0,0),
        mk_o(0,1,4'hF,32'h100,32'hDEADBEEF, 0,0,0,0,0));
    add(mk_i(1,1,32'h10,0,0,0,0,0,                     0,0),
        mk_o(1,0,0,32'h10,0,                0,0,0,0,0));
    add(mk_i(1,1,32'h10,0,0,0,0,0,                     1,32'h00500093),
        mk_o(0,0,0,32'h10,0,                1,32'h00500093,0,0,0));
    add(mk_i(1,1,32'h10,0,0,0,0,0,                     0,32'hFFFF),
        mk_o(0,0,0,32'h10,0,                0,32'h00500093,0,0,0));
    add(mk_i(1,0,0,     0,0,0,0,0,                     0,0),
        mk_o(0,0,0,32'h10,0,                0,32'h00500093,0,0,0));
    add(mk_i(1,1,32'h20,1,0,4'hF,32'h200,32'h11111111, 0,0),
        mk_o(1,0,0,32'h200,0,               0,32'h00500093,0,0,0));
    add(mk_i(1,1,32'h20,1,0,4'hF,32'h200,32'h11111111, 1,32'hAAAA5555),
        mk_o(0,0,0,32'h200,0,               0,32'h00500093,1,32'hAAAA5555,0));
    add(mk_i(1,1,32'h20,1,0,4'hF,32'h200,32'h11111111, 0,0),
        mk_o(1,0,0,32'h20,0,                0,32'h00500093,0,32'hAAAA5555,0));
    add(mk_i(1,1,32'h20,1,0,4'hF,32'h200,32'h11111111, 1,32'h0BADC0DE),
        mk_o(0,0,0,32'h20,0,                1,32'h0BADC0DE,0,32'hAAAA5555,0));
    add(mk_i(1,1,32'h20,1,0,4'hF,32'h200,32'h11111111, 0,0),
        mk_o(1,0,0,32'h200,0,               0,32'h0BADC0DE,0,32'hAAAA5555,0));
    add(mk_i(1,0,0,     1,0,4'hF,32'h200,32'h11111111, 1,32'h12345678),
        mk_o(0,0,0,32'h200,0,               0,32'h0BADC0DE,1,32'h12345678,0));
    add(mk_i(1,0,0,     0,0,0,0,0,                     0,0),
        mk_o(0,0,0,32'h200,0,               0,32'h0BADC0DE,0,32'h12345678,0));
    // Both fresh after a data grant: round robin picks fetch, fixed priority picks data.
    w_a = RR ? 32'h30 : 32'h300;
    l_a = RR ? 32'h300 : 32'h30;
    add(mk_i(1,1,32'h30,1,0,0,32'h300,0, 0,0),
        mk_o(1,0,0,w_a,0, 0,32'h0BADC0DE,0,32'h12345678,0));
    add(mk_i(1,1,32'h30,1,0,0,32'h300,0, 1,32'h77),
        mk_o(0,0,0,w_a,0, RR,RR ? 32'h77 : 32'h0BADC0DE,!RR,RR ? 32'h12345678 : 32'h77,0));
    add(mk_i(1,!RR,32'h30,RR,0,0,32'h300,0, 0,0),
        mk_o(1,0,0,l_a,0, 0,RR ? 32'h77 : 32'h0BADC0DE,0,RR ? 32'h12345678 : 32'h77,0));
    add(mk_i(1,!RR,32'h30,RR,0,0,32'h300,0, 1,32'h88),
        mk_o(0,0,0,l_a,0, !RR,RR ? 32'h77 : 32'h88,RR,RR ? 32'h88 : 32'h77,0));
    add(mk_i(1,0,0,0,0,0,0,0, 0,0),
        mk_o(0,0,0,l_a,0, 0,RR ? 32'h77 : 32'h88,0,RR ? 32'h88 : 32'h77,0));

    // Reset state
    drive(mk_i(0,0,0,0,0,0,0,0,0,0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", mk_o(0,0,0,0,0,0,0,0,0,0));

    foreach (tbl[k]) begin
      drive(tbl[k].i);
      step();
      check($sformatf("vec%0d", k), tbl[k].o);
    end

    // Load left unacknowledged: aborts after TMO cycles of mem_req, reads back zero.
    drive(mk_i(1,0,0,1,0,0,32'h400,0,0,32'h5A5A5A5A));
    hi = 0; nv = 0; vd = 32'hFFFFFFFF; vto = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (mem_req) hi++;
      if (d_valid) begin
        nv++; vd = d_rdata; vto = timeout; d_req = 1'b0;
      end
    end
    chk("tmo_req_cycles", 32'(hi), 32'(TMO));
    chk("tmo_valid_pulses", 32'(nv), 32'd1);
    chk("tmo_rdata", vd, 32'h0);
    chk("tmo_flag_at_valid", 32'(vto), 32'd1);
    repeat (3) step();
    chk("tmo_sticky", 32'(timeout), 32'd1);

    // Reset while a fetch is waiting abandons it and clears the sticky flag.
    drive(mk_i(1,1,32'h44,0,0,0,0,0,0,0));
    step();
    chk("rst_pre_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    step();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_ifv", 32'(if_valid), 32'd0);
    chk("rst_tmo", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_regrant_req", 32'(mem_req), 32'd1);
    chk("rst_regrant_addr", mem_addr, 32'h44);
    mem_ack = 1'b1; mem_rdata = 32'h99;
    step();
    chk("rst_fetch_valid", 32'(if_valid), 32'd1);
    chk("rst_fetch_data", if_rdata, 32'h99);
    if_req = 1'b0; mem_ack = 1'b0;
    step();
    chk("rst_fetch_pulse", 32'(if_valid), 32'd0);

    // Randomized traffic against the model, starting from a reset.
    v = mk_i(0,0,0,0,0,0,0,0,0,0);
    m = '0;
    drive(v);
    step();
    if_act = 1'b0; d_act = 1'b0;
    ra = 0; rd_a = 0; r_wd = 0; r_m = 0; r_we = 0;
    for (int c = 0; c < 3000; c++) begin
      if (if_act && m.o.if_valid) if_act = 1'b0;
      if (d_act && m.o.d_valid) d_act = 1'b0;
      if (!if_act && ($urandom_range(0, 2) == 0)) begin
        if_act = 1'b1; ra = $urandom;
      end
      if (!d_act && ($urandom_range(0, 2) == 0)) begin
        d_act = 1'b1; rd_a = $urandom; r_wd = $urandom;
        r_m = 4'($urandom); r_we = 1'($urandom);
      end
      v = mk_i($urandom_range(0, 199) != 0, if_act, ra, d_act, r_we, r_m, rd_a, r_wd,
               m.o.mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0),
               $urandom);
      drive(v);
      m = model_step(m, v);
      step();
      check($sformatf("rand%0d", c), m.o);
      chk("valid_exclusive", 32'(if_valid & d_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
